div: RTL and testbench
======================

DIV -- requirements
Module: div

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 The block SHALL have the port div_data1_i, input, 32 bits: dividend from the EX stage.
REQ-004 The block SHALL have the port div_data2_i, input, 32 bits: divisor from the EX stage.
REQ-005 The block SHALL have the port div_singed_i, input, 1 bit: 1 = signed (div.w/mod.w), 0 = unsigned (div.wu/mod.wu).
REQ-006 The block SHALL have the port div_start_i, input, 1 bit: the request, held high by EX until it sees done.
REQ-007 The block SHALL have the port div_result_o, output, 64 bits, registered: {remainder[63:32], quotient[31:0]}.
REQ-008 The block SHALL have the port div_done_o, output, 1 bit, registered: result valid, high for exactly one cycle.

Function
REQ-009 The FSM SHALL have four states, with encodings in the shared package: DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END.
REQ-010 In DIV_FREE with div_start_i=1, the block SHALL go to DIV_BY_ZERO if div_data2_i==0, else to DIV_ON.
REQ-011 On leaving DIV_FREE for DIV_ON, the block SHALL capture the operands:
- signed mode: |dividend|, |divisor| (two's-complement negate when bit31=1), original sign bits and mode;
- unsigned mode: operands as given.
REQ-012 The iteration counter (6 bits) SHALL clear on entry to DIV_ON.
REQ-013 DIV_ON SHALL perform one restoring shift-subtract step per cycle on a 65-bit partial remainder:
- shift left 1;
- compare the upper 33 bits against {1'b0, divisor};
- subtract and set the quotient LSB on success.
REQ-014 After exactly 32 steps (counter 0..31), the FSM SHALL go to DIV_END.
REQ-015 Sign fix-up SHALL apply in signed mode only:
- quotient negated when dividend sign XOR divisor sign = 1;
- remainder negated when the dividend sign = 1.
REQ-016 0x8000_0000 / 0xFFFF_FFFF in signed mode SHALL yield quotient 0x8000_0000 and remainder 0 (natural 32-bit wrap, no trap).
REQ-017 DIV_BY_ZERO SHALL load quotient 0xFFFF_FFFF, remainder = dividend (raw, no fix-up), then go to DIV_END.
REQ-018 DIV_END SHALL drive div_done_o=1 with div_result_o holding the final value, then unconditionally return to DIV_FREE on the next edge.
- This holds even though div_start_i drops combinationally in the same cycle.
REQ-019 Latency, with start first sampled at the edge ending cycle n:
- div_done_o=1 in cycle n+34 for nonzero divisors;
- div_done_o=1 in cycle n+2 for a zero divisor.
REQ-020 In DIV_ON or DIV_BY_ZERO, div_start_i=0 SHALL abort to DIV_FREE on the next edge: div_done_o stays 0 and the result register is unchanged (pipeline flush).
REQ-021 Back-to-back requests SHALL be supported:
- div_start_i=1 in the cycle after DIV_END is sampled in DIV_FREE as a new request;
- operands SHALL NOT be re-sampled while busy.
REQ-022 div_done_o SHALL be 0 in all states except DIV_END.
REQ-023 div_result_o SHALL change only on the DIV_END entry edge.

Reset
REQ-024 On rst=1 the block SHALL asynchronously force:
- state DIV_FREE;
- counter 0;
- partial remainder and operand registers 0;
- div_result_o=64'h0, div_done_o=0.
REQ-025 Reset mid-operation SHALL discard the operation with no done pulse; the first request after release SHALL behave as from cold.

Structure
REQ-026 The state encodings (2-bit) and the divide-by-zero quotient constant SHALL live in the shared define package; 64-bit results SHALL reuse the existing double-register-width macro.
REQ-027 The block SHALL be a single module with no sub-module; the step logic is inline.
REQ-028 The design SHALL use one sequential process for state/datapath and one combinational process for next-state logic.

Verification
REQ-029 Unsigned 100/7, start held until done SHALL give done at cycle n+34 with result {32'd2, 32'd14}.
REQ-030 Signed -7/2 (0xFFFF_FFF9 / 2) SHALL give quotient 0xFFFF_FFFD and remainder 0xFFFF_FFFF; signed 7/-2 SHALL give quotient 0xFFFF_FFFD and remainder 1.
REQ-031 Signed 0x8000_0000 / 0xFFFF_FFFF SHALL give {0, 0x8000_0000}.
REQ-032 Divide-by-zero 0x1234 / 0 SHALL give done at cycle n+2 with {0x0000_1234, 0xFFFF_FFFF}.
REQ-033 Deasserting start at step 10 SHALL produce no done pulse and a return to DIV_FREE; a following 9/3 request SHALL yield {0, 3}.
REQ-034 Asserting rst at step 20 (asynchronous, mid-cycle) SHALL clear the outputs immediately; two back-to-back requests 0xFFFF_FFFF/0x10 (unsigned) then 15/4 SHALL give {0xF, 0x0FFF_FFFF} then {3, 3}, with no lost or duplicated done.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM encodings, widths and
// the divide-by-zero quotient constant.
package div_pkg;

  localparam int REG_W        = 32;
  localparam int DOUBLE_REG_W = 2 * REG_W;
  localparam int DIV_CNT_W    = 6;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'd0,
    DIV_BY_ZERO = 2'd1,
    DIV_ON      = 2'd2,
    DIV_END     = 2'd3
  } div_state_t;

  localparam logic [REG_W-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/div.sv
// Multi-cycle restoring divider for div.w/div.wu/mod.w/mod.wu: one quotient bit per
// cycle on magnitudes, sign fix-up on the final edge, result as {remainder, quotient}.
module div
  import div_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REG_W-1:0]        div_data1_i,
  input  logic [REG_W-1:0]        div_data2_i,
  input  logic                    div_singed_i,
  input  logic                    div_start_i,
  output logic [DOUBLE_REG_W-1:0] div_result_o,
  output logic                    div_done_o
);

  localparam int                   DATA_W   = REG_W;
  localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(DATA_W);

  div_state_t state, state_nxt;

  logic [DIV_CNT_W-1:0] cnt;
  logic [2*DATA_W:0]    rem;
  logic [DATA_W-1:0]    divisor;
  logic [DATA_W-1:0]    dividend_raw;
  logic                 sign_a, sign_b, signed_mode;

  logic signed [DATA_W-1:0] a_s, b_s;
  logic                     neg_a, neg_b;

  logic [2*DATA_W:0] rem_sh, rem_step;
  logic [DATA_W:0]   rem_diff;
  logic              step_ok;
  logic [DATA_W-1:0] quot_fix, rem_fix;

  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  assign a_s   = div_data1_i;
  assign b_s   = div_data2_i;
  assign neg_a = div_singed_i && (a_s < 0);
  assign neg_b = div_singed_i && (b_s < 0);

  // One restoring step: shift, trial-subtract the divisor from the upper 33 bits.
  assign rem_sh   = rem << 1;
  assign step_ok  = rem_sh[2*DATA_W:DATA_W] >= {1'b0, divisor};
  assign rem_diff = rem_sh[2*DATA_W:DATA_W] - {1'b0, divisor};
  assign rem_step = step_ok ? {rem_diff, rem_sh[DATA_W-1:1], 1'b1} : rem_sh;

  // Magnitude results back to signed form; -2^31 / -1 wraps naturally.
  assign quot_fix = neg_if(rem[DATA_W-1:0], signed_mode & (sign_a ^ sign_b));
  assign rem_fix  = neg_if(rem[2*DATA_W-1:DATA_W], signed_mode & sign_a);

  always_comb begin
    state_nxt = state;
    unique case (state)
      DIV_FREE: begin
        if (div_start_i) state_nxt = (div_data2_i == '0) ? DIV_BY_ZERO : DIV_ON;
      end
      DIV_BY_ZERO: state_nxt = div_start_i ? DIV_END : DIV_FREE;
      DIV_ON: begin
        if (!div_start_i)          state_nxt = DIV_FREE;
        else if (cnt == CNT_LAST)  state_nxt = DIV_END;
      end
      DIV_END:  state_nxt = DIV_FREE;
      default:  state_nxt = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= DIV_FREE;
      cnt          <= '0;
      rem          <= '0;
      divisor      <= '0;
      dividend_raw <= '0;
      sign_a       <= 1'b0;
      sign_b       <= 1'b0;
      signed_mode  <= 1'b0;
      div_result_o <= '0;
      div_done_o   <= 1'b0;
    end else begin
      state      <= state_nxt;
      div_done_o <= (state_nxt == DIV_END);
      unique case (state)
        DIV_FREE: begin
          if (div_start_i) begin
            signed_mode  <= div_singed_i;
            sign_a       <= neg_a;
            sign_b       <= neg_b;
            dividend_raw <= div_data1_i;
            divisor      <= neg_if(div_data2_i, neg_b);
            rem          <= {{(DATA_W+1){1'b0}}, neg_if(div_data1_i, neg_a)};
            cnt          <= '0;
          end
        end
        DIV_BY_ZERO: begin
          if (div_start_i) div_result_o <= {dividend_raw, DIV_ZERO_QUOT};
        end
        DIV_ON: begin
          if (div_start_i) begin
            if (cnt == CNT_LAST) begin
              div_result_o <= {rem_fix, quot_fix};
            end else begin
              rem <= rem_step;
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Bench for the iterative divider: cycle-level reference model plus directed vectors.
module tb_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] d1 = '0, d2 = '0;
  logic        sg = 1'b0, start = 1'b0;
  logic [63:0] result;
  logic        done;

  int errs = 0;
  int checks = 0;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .div_data1_i  (d1),
    .div_data2_i  (d2),
    .div_singed_i (sg),
    .div_start_i  (start),
    .div_result_o (result),
    .div_done_o   (done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference timing: a request taken when idle completes 34 cycles later (2 for /0);
  // dropping start while busy abandons it; the done cycle ignores start.
  int          busy_left = 0;
  logic        m_done = 1'b0;
  logic [63:0] m_res = '0, m_pend = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_left = 0;
      m_done    = 1'b0;
      m_res     = '0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (busy_left == 0) begin
      if (start) begin
        busy_left = (d2 == 32'd0) ? 1 : 33;
        m_pend    = model(d1, d2, sg);
      end
    end else if (!start) begin
      busy_left = 0;
    end else begin
      busy_left--;
      if (busy_left == 0) begin
        m_done = 1'b1;
        m_res  = m_pend;
      end
    end
  end

  always @(negedge clk) begin
    chk(done === m_done, "done_cycle", {63'd0, done}, {63'd0, m_done});
    chk(result === m_res, "result_cycle", result, m_res);
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [63:0] exp, input int exp_lat, input string name);
    int  lat;
    bit  seen;
    @(posedge clk); #1;
    d1 = a; d2 = b; sg = s; start = 1'b1;
    seen = 1'b0;
    lat  = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
    end
    start = 1'b0;
    chk(seen, {name, "_done_seen"}, {63'd0, seen}, 64'd1);
    chk(lat == exp_lat, {name, "_latency"}, 64'(lat), 64'(exp_lat));
    chk(result === exp, {name, "_value"}, result, exp);
  endtask

  task automatic abort_after(input logic [31:0] a, input logic [31:0] b, input int steps, input string name);
    bit saw = 1'b0;
    @(posedge clk); #1;
    d1 = a; d2 = b; sg = 1'b0; start = 1'b1;
    repeat (steps + 1) @(negedge clk);
    start = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw = 1'b1;
    end
    chk(!saw, {name, "_no_done"}, {63'd0, saw}, 64'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk(result === 64'd0, "reset_result", result, 64'd0);
    chk(done === 1'b0, "reset_done", {63'd0, done}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Model pins
    chk(model(32'd100, 32'd7, 1'b0) == {32'd2, 32'd14}, "model_u", model(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
    chk(model(32'hFFFF_FFF9, 32'd2, 1'b1) == {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "model_s",
        model(32'hFFFF_FFF9, 32'd2, 1'b1), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    chk(model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1) == {32'd0, 32'h8000_0000}, "model_ovf",
        model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), {32'd0, 32'h8000_0000});

    run_op(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 34, "u100_7");
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34, "s_m7_2");
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, {32'd1, 32'hFFFF_FFFD}, 34, "s_7_m2");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000}, 34, "s_ovf");
    run_op(32'h0000_1234, 32'd0, 1'b0, {32'h0000_1234, 32'hFFFF_FFFF}, 2, "dbz");
    run_op(32'hFFFF_FFF9, 32'd0, 1'b1, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 2, "dbz_signed_raw");
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, {32'd0, 32'hFFFF_FFFF}, 34, "u_max_1");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'd1}, 34, "s_m1_m1");

    abort_after(32'd10000, 32'd3, 10, "abort_on");
    run_op(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 34, "u9_3");
    abort_after(32'd55, 32'd0, 1, "abort_dbz");
    chk(result === {32'd0, 32'd3}, "abort_keeps_result", result, {32'd0, 32'd3});

    // Asynchronous reset in the middle of step 20
    @(posedge clk); #1;
    d1 = 32'hFFFF_FFFF; d2 = 32'h10; sg = 1'b0; start = 1'b1;
    repeat (21) @(negedge clk);
    #2;
    rst = 1'b1;
    start = 1'b0;
    #1;
    chk(result === 64'd0, "rst_mid_result", result, 64'd0);
    chk(done === 1'b0, "rst_mid_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(32'hFFFF_FFFF, 32'h10, 1'b0, {32'hF, 32'h0FFF_FFFF}, 34, "b2b_first");
    run_op(32'd15, 32'd4, 1'b0, {32'd3, 32'd3}, 34, "b2b_second");
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
